// File: rtl/v_regfile.sv
// Vector register file: 2^VREG_AW x VREG_DW entries, two registered read ports
// with write-first bypass, and a per-register busy scoreboard for issued writes.
module v_regfile #(
    parameter int VREG_DW = 256,
    parameter int VREG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vwb_en_i,
    input  logic [VREG_AW-1:0] vwb_addr_i,
    input  logic [VREG_DW-1:0] vwb_data_i,
    input  logic               vrs1_en_i,
    input  logic [VREG_AW-1:0] vrs1_addr_i,
    output logic [VREG_DW-1:0] vrs1_data_o,
    input  logic               vrs2_en_i,
    input  logic [VREG_AW-1:0] vrs2_addr_i,
    output logic [VREG_DW-1:0] vrs2_data_o,
    input  logic               vd_issue_en_i,
    input  logic [VREG_AW-1:0] vd_issue_addr_i,
    output logic               vrs1_busy_o,
    output logic               vrs2_busy_o
);

    localparam int NREGS = 1 << VREG_AW;

    logic [VREG_DW-1:0] regs [NREGS];
    logic [NREGS-1:0]   sb;
    logic [NREGS-1:0]   sb_next;
    logic               wb_hit1;
    logic               wb_hit2;

    assign wb_hit1 = vwb_en_i && (vwb_addr_i == vrs1_addr_i);
    assign wb_hit2 = vwb_en_i && (vwb_addr_i == vrs2_addr_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (vwb_en_i) begin
            regs[vwb_addr_i] <= vwb_data_i;
        end
    end

    // Issue is applied after writeback so a same-address collision leaves the bit set.
    always_comb begin
        sb_next = sb;
        if (vwb_en_i) begin
            sb_next[vwb_addr_i] = 1'b0;
        end
        if (vd_issue_en_i) begin
            sb_next[vd_issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vrs1_data_o <= '0;
            vrs2_data_o <= '0;
        end else begin
            if (vrs1_en_i) begin
                vrs1_data_o <= wb_hit1 ? vwb_data_i : regs[vrs1_addr_i];
            end
            if (vrs2_en_i) begin
                vrs2_data_o <= wb_hit2 ? vwb_data_i : regs[vrs2_addr_i];
            end
        end
    end

    // A writeback landing this cycle already satisfies the dependency.
    assign vrs1_busy_o = sb[vrs1_addr_i] && !wb_hit1;
    assign vrs2_busy_o = sb[vrs2_addr_i] && !wb_hit2;

endmodule

// File: tb/tb_v_regfile.sv
// Directed bench for v_regfile: reset, read latency/hold, bypass, scoreboard
// set/clear/priority, and asynchronous mid-cycle reset.
module tb_v_regfile;

    localparam int DW = 256;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          vwb_en_i;
    logic [AW-1:0] vwb_addr_i;
    logic [DW-1:0] vwb_data_i;
    logic          vrs1_en_i;
    logic [AW-1:0] vrs1_addr_i;
    logic [DW-1:0] vrs1_data_o;
    logic          vrs2_en_i;
    logic [AW-1:0] vrs2_addr_i;
    logic [DW-1:0] vrs2_data_o;
    logic          vd_issue_en_i;
    logic [AW-1:0] vd_issue_addr_i;
    logic          vrs1_busy_o;
    logic          vrs2_busy_o;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] pat_a5;
    logic [DW-1:0] pat_1234;
    logic [DW-1:0] pat_ff;
    logic [DW-1:0] pat_junk;

    v_regfile #(.VREG_DW(DW), .VREG_AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .vwb_en_i        (vwb_en_i),
        .vwb_addr_i      (vwb_addr_i),
        .vwb_data_i      (vwb_data_i),
        .vrs1_en_i       (vrs1_en_i),
        .vrs1_addr_i     (vrs1_addr_i),
        .vrs1_data_o     (vrs1_data_o),
        .vrs2_en_i       (vrs2_en_i),
        .vrs2_addr_i     (vrs2_addr_i),
        .vrs2_data_o     (vrs2_data_o),
        .vd_issue_en_i   (vd_issue_en_i),
        .vd_issue_addr_i (vd_issue_addr_i),
        .vrs1_busy_o     (vrs1_busy_o),
        .vrs2_busy_o     (vrs2_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        vwb_en_i      = 1'b0;
        vrs1_en_i     = 1'b0;
        vrs2_en_i     = 1'b0;
        vd_issue_en_i = 1'b0;
    endtask

    initial begin
        pat_a5   = {32{8'hA5}};
        pat_1234 = {16{16'h1234}};
        pat_ff   = {DW{1'b1}};
        pat_junk = {8{32'hDEADBEEF}};

        rst = 1'b0;
        idle();
        vwb_addr_i = '0; vwb_data_i = '0;
        vrs1_addr_i = '0; vrs2_addr_i = '0; vd_issue_addr_i = '0;
        step();
        step();
        check("reset_rd1", vrs1_data_o, '0);
        check("reset_rd2", vrs2_data_o, '0);
        rst = 1'b1;

        // Fresh registers read as zero on both ports.
        vrs1_en_i = 1'b1; vrs1_addr_i = 5'd3;
        vrs2_en_i = 1'b1; vrs2_addr_i = 5'd3;
        step();
        check("v3_rd1", vrs1_data_o, '0);
        check("v3_rd2", vrs2_data_o, '0);
        check("v3_busy1", {255'd0, vrs1_busy_o}, '0);
        check("v3_busy2", {255'd0, vrs2_busy_o}, '0);

        // Write v5 then read it back with one-cycle latency.
        idle();
        vwb_en_i = 1'b1; vwb_addr_i = 5'd5; vwb_data_i = pat_a5;
        step();
        idle();
        vrs1_en_i = 1'b1; vrs1_addr_i = 5'd5;
        step();
        check("v5_rd1", vrs1_data_o, pat_a5);
        idle();
        vrs1_addr_i = 5'd0;
        step();
        check("v5_hold1", vrs1_data_o, pat_a5);
        step();
        check("v5_hold2", vrs1_data_o, pat_a5);

        // Disabled write must not land.
        vwb_addr_i = 5'd5; vwb_data_i = pat_junk;
        step();
        vrs1_en_i = 1'b1; vrs1_addr_i = 5'd5;
        step();
        check("v5_no_write", vrs1_data_o, pat_a5);

        // Same-cycle write and read of v7: bypass on port 2.
        idle();
        vwb_en_i = 1'b1; vwb_addr_i = 5'd7; vwb_data_i = pat_1234;
        vrs2_en_i = 1'b1; vrs2_addr_i = 5'd7;
        step();
        check("v7_bypass2", vrs2_data_o, pat_1234);

        // Both ports read v7 together.
        idle();
        vrs1_en_i = 1'b1; vrs1_addr_i = 5'd7;
        vrs2_en_i = 1'b1; vrs2_addr_i = 5'd7;
        step();
        check("v7_dual_rd1", vrs1_data_o, pat_1234);
        check("v7_dual_rd2", vrs2_data_o, pat_1234);

        // Issue v9: busy next cycle, cleared combinationally by writeback.
        idle();
        vd_issue_en_i = 1'b1; vd_issue_addr_i = 5'd9;
        step();
        idle();
        vrs1_addr_i = 5'd9; vrs2_addr_i = 5'd9;
        #1;
        check("v9_busy1", {255'd0, vrs1_busy_o}, 256'd1);
        check("v9_busy2", {255'd0, vrs2_busy_o}, 256'd1);
        vwb_en_i = 1'b1; vwb_addr_i = 5'd9; vwb_data_i = pat_junk;
        #1;
        check("v9_wb_same_cycle", {255'd0, vrs1_busy_o}, '0);
        step();
        idle();
        #1;
        check("v9_after_wb", {255'd0, vrs1_busy_o}, '0);

        // Issue and writeback of v4 together while busy: stays busy.
        vd_issue_en_i = 1'b1; vd_issue_addr_i = 5'd4;
        step();
        idle();
        vrs1_addr_i = 5'd4;
        #1;
        check("v4_busy", {255'd0, vrs1_busy_o}, 256'd1);
        vd_issue_en_i = 1'b1; vd_issue_addr_i = 5'd4;
        vwb_en_i = 1'b1; vwb_addr_i = 5'd4; vwb_data_i = pat_a5;
        #1;
        check("v4_collide_masked", {255'd0, vrs1_busy_o}, '0);
        step();
        idle();
        #1;
        check("v4_set_wins", {255'd0, vrs1_busy_o}, 256'd1);
        vrs2_en_i = 1'b1; vrs2_addr_i = 5'd4;
        step();
        idle();
        #1;
        check("v4_read_no_clear", {255'd0, vrs1_busy_o}, 256'd1);
        check("v4_data", vrs2_data_o, pat_a5);

        // Write v2, mark it busy, then reset mid-cycle.
        vwb_en_i = 1'b1; vwb_addr_i = 5'd2; vwb_data_i = pat_ff;
        step();
        idle();
        vd_issue_en_i = 1'b1; vd_issue_addr_i = 5'd2;
        step();
        idle();
        vrs1_en_i = 1'b1; vrs1_addr_i = 5'd2;
        step();
        idle();
        check("v2_rd_before_rst", vrs1_data_o, pat_ff);
        check("v2_busy_before_rst", {255'd0, vrs1_busy_o}, 256'd1);
        vwb_en_i = 1'b1; vwb_addr_i = 5'd2; vwb_data_i = pat_junk;
        vd_issue_en_i = 1'b1; vd_issue_addr_i = 5'd6;
        #2;
        rst = 1'b0;
        #1;
        vwb_en_i = 1'b0;
        #1;
        check("rst_async_rd1", vrs1_data_o, '0);
        check("rst_async_rd2", vrs2_data_o, '0);
        check("rst_async_busy1", {255'd0, vrs1_busy_o}, '0);
        vwb_en_i = 1'b1;
        vrs1_en_i = 1'b1;
        step();
        step();
        check("rst_held_rd1", vrs1_data_o, '0);
        idle();
        rst = 1'b1;
        vrs1_en_i = 1'b1; vrs1_addr_i = 5'd2;
        vrs2_en_i = 1'b1; vrs2_addr_i = 5'd5;
        step();
        idle();
        vrs2_addr_i = 5'd6;
        #1;
        check("v2_after_rst", vrs1_data_o, '0);
        check("v5_after_rst", vrs2_data_o, '0);
        check("v2_busy_after_rst", {255'd0, vrs1_busy_o}, '0);
        check("v6_issue_dropped", {255'd0, vrs2_busy_o}, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/v_regfile.md
V_REGFILE -- requirements
Module: v_regfile

Interface
REQ-001 SHALL have parameter VREG_DW, default 256, vector register width in bits.
REQ-002 SHALL have parameter VREG_AW, default 5, register address width (2^VREG_AW entries).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port vwb_en_i  input  1  writeback enable from the writeback stage.
REQ-006 SHALL have port vwb_addr_i  input  VREG_AW  writeback destination register.
REQ-007 SHALL have port vwb_data_i  input  VREG_DW  writeback data.
REQ-008 SHALL have port vrs1_en_i  input  1  read request, port 1.
REQ-009 SHALL have port vrs1_addr_i  input  VREG_AW  read address, port 1.
REQ-010 SHALL have port vrs1_data_o  output  VREG_DW  registered read data, port 1.
REQ-011 SHALL have port vrs2_en_i, vrs2_addr_i, vrs2_data_o, identical to port 1 in direction, width and meaning.
REQ-012 SHALL have port vd_issue_en_i  input  1  an instruction writing a vector register was issued.
REQ-013 SHALL have port vd_issue_addr_i  input  VREG_AW  destination of the issued instruction.
REQ-014 SHALL have port vrs1_busy_o, vrs2_busy_o  output  1 each  source register has an outstanding write.

Function
REQ-015 SHALL hold 2^VREG_AW registers of VREG_DW bits; no register is hardwired.
REQ-016 SHALL write vwb_data_i into entry vwb_addr_i on a rising edge where vwb_en_i=1; no write when vwb_en_i=0.
REQ-017 SHALL update vrsN_data_o on the rising edge after vrsN_en_i=1 (1-cycle latency) and hold it while vrsN_en_i=0.
REQ-018 SHALL return vwb_data_i on vrsN_data_o when a read and a write target the same address in the same cycle (write-first bypass).
REQ-019 SHALL let both read ports access the same address in the same cycle with identical results.
REQ-020 SHALL keep one scoreboard bit per register; vd_issue_en_i=1 sets bit vd_issue_addr_i at the next edge.
REQ-021 SHALL clear scoreboard bit vwb_addr_i at the next edge when vwb_en_i=1.
REQ-022 SHALL give set priority over clear when issue and writeback target the same address in the same cycle (bit ends at 1).
REQ-023 SHALL drive vrsN_busy_o combinationally as scoreboard[vrsN_addr_i] AND NOT (vwb_en_i AND vwb_addr_i==vrsN_addr_i).
REQ-024 SHALL NOT let a read request alter scoreboard or register contents.

Reset
REQ-025 SHALL, while rst=0, immediately clear all registers, all scoreboard bits, vrs1_data_o and vrs2_data_o to 0, independent of clk.
REQ-026 SHALL ignore all writes, reads and issues while rst=0; normal operation resumes at the first rising edge with rst=1.
REQ-027 SHALL discard any write or issue presented in the cycle reset asserts; no partial update survives.

Verification
REQ-028 Release reset, read v3 on both ports -> vrs1_data_o=vrs2_data_o=0 one cycle later; both busy=0.
REQ-029 Write v5=0xA5 repeated, read v5 next cycle -> vrs1_data_o=0xA5.. one cycle after read request; data holds with vrs1_en_i=0.
REQ-030 Same cycle: write v7=0x1234..., read v7 on port 2 -> vrs2_data_o=0x1234... next edge (bypass).
REQ-031 Issue v9; next cycle vrs1_addr_i=9 -> busy=1; cycle with vwb_en_i=1, addr 9 -> busy=0 same cycle, stays 0 after.
REQ-032 Same cycle issue v4 and writeback v4 with v4 busy -> bit stays 1, vrs1_busy_o=1 the following cycle.
REQ-033 Write v2=0xFF.., set busy v2, assert rst=0 mid-cycle -> data outputs 0 and busy 0 immediately; read v2 after release -> 0.
